// File: rtl/ascon_inv_permutation.sv
// Iterative inverse of the Ascon p^a permutation, UNROLL (1 or 2) inverse rounds per clock.
// Define ASCON_INV_ABORT_EN to add an abort input that drops an in-flight job back to IDLE.
module ascon_inv_permutation #(
  parameter int UNROLL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ASCON_INV_ABORT_EN
  input  logic        abort,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  nrounds,
  input  logic [63:0] x0,
  input  logic [63:0] x1,
  input  logic [63:0] x2,
  input  logic [63:0] x3,
  input  logic [63:0] x4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] xo0,
  output logic [63:0] xo1,
  output logic [63:0] xo2,
  output logic [63:0] xo3,
  output logic [63:0] xo4
);

  typedef logic [4:0][63:0] state_t;  // [0] = x0 ... [4] = x4
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  localparam logic [4:0] INV_SBOX [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Sigma has order 64, so Sigma^-1 = Sigma^63 = product of Sigma^(2^k) for k = 0..5.
  function automatic logic [63:0] inv_lin(input logic [63:0] x, input int p, input int q);
    logic [63:0] y;
    y = x;
    for (int k = 0; k < 6; k++) begin
      y = y ^ ror64(y, (p << k) % 64) ^ ror64(y, (q << k) % 64);
    end
    return y;
  endfunction

  function automatic state_t inv_round(input state_t s, input logic [3:0] r);
    state_t     t;
    state_t     u;
    logic [4:0] col;
    logic [4:0] v;
    t[0] = inv_lin(s[0], 19, 28);
    t[1] = inv_lin(s[1], 61, 39);
    t[2] = inv_lin(s[2],  1,  6);
    t[3] = inv_lin(s[3], 10, 17);
    t[4] = inv_lin(s[4],  7, 41);
    for (int i = 0; i < 64; i++) begin
      col = {t[0][i], t[1][i], t[2][i], t[3][i], t[4][i]};
      v   = INV_SBOX[col];
      for (int w = 0; w < 5; w++) begin
        u[w][i] = v[4-w];
      end
    end
    u[2][7:0] = u[2][7:0] ^ {4'hF - r, r};
    return u;
  endfunction

  fsm_e       fsm_q;
  state_t     x_q;
  logic [3:0] rc_q;
  logic [3:0] rem_q;
  logic       in_ready_q;
  logic       out_valid_q;

  state_t     stage1_d;
  state_t     stage2_d;
  logic [3:0] n_clamped;
  logic       two_step;
  logic       abort_w;

`ifdef ASCON_INV_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign n_clamped = (nrounds > 4'd12) ? 4'd12 : nrounds;
  assign stage1_d  = inv_round(x_q, rc_q);
  assign stage2_d  = inv_round(stage1_d, rc_q - 4'd1);
  // The second stage is bypassed when only one round remains (odd round count).
  assign two_step  = (UNROLL == 2) && (rem_q >= 4'd2);

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  // NOTE: the datapath register is reset too, because xo* must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      x_q         <= '0;
      rc_q        <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= {x4, x3, x2, x1, x0};
            rc_q       <= 4'd11;
            rem_q      <= n_clamped;
            in_ready_q <= 1'b0;
            if (n_clamped == 4'd0) begin
              fsm_q       <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              fsm_q <= RUN;
            end
          end
        end
        RUN: begin
          if (abort_w) begin
            fsm_q      <= IDLE;
            x_q        <= '0;
            in_ready_q <= 1'b1;
          end else begin
            if (two_step) begin
              x_q   <= stage2_d;
              rc_q  <= rc_q - 4'd2;
              rem_q <= rem_q - 4'd2;
            end else begin
              x_q   <= stage1_d;
              rc_q  <= rc_q - 4'd1;
              rem_q <= rem_q - 4'd1;
            end
            if (rem_q == (two_step ? 4'd2 : 4'd1)) begin
              fsm_q       <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (abort_w) begin
            fsm_q       <= IDLE;
            x_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end else if (out_ready) begin
            fsm_q       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          fsm_q       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign xo0       = x_q[0];
  assign xo1       = x_q[1];
  assign xo2       = x_q[2];
  assign xo3       = x_q[3];
  assign xo4       = x_q[4];

endmodule

// File: tb/tb_ascon_inv_permutation.sv
// Scoreboard bench for ascon_inv_permutation: UNROLL=1 and UNROLL=2 instances share one stimulus stream.
module tb_ascon_inv_permutation;

  typedef logic [4:0][63:0] st_t;
  typedef struct {
    st_t st;
    int  acc;
    int  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  nrounds = 4'd0;
  st_t         x_in = '0;
  logic [1:0]  out_ready = 2'b00;
`ifdef ASCON_INV_ABORT_EN
  logic        abort = 1'b0;
`endif
  wire  [1:0]       in_ready;
  wire  [1:0]       out_valid;
  wire  [4:0][63:0] xo_a;
  wire  [4:0][63:0] xo_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   seen [2];
  st_t  held [2];
  bit   or_force = 1'b0;
  bit   or_val = 1'b0;

  byte unsigned inv_tab [32] = '{
    8'h14, 8'h1a, 8'h07, 8'h0d, 8'h00, 8'h09, 8'h0e, 8'h12,
    8'h0a, 8'h06, 8'h1d, 8'h01, 8'h19, 8'h15, 8'h13, 8'h1e,
    8'h18, 8'h16, 8'h0b, 8'h11, 8'h03, 8'h05, 8'h1c, 8'h1f,
    8'h17, 8'h1b, 8'h04, 8'h08, 8'h0f, 8'h0c, 8'h10, 8'h02
  };
  int fwd_tab [32];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ascon_inv_permutation #(.UNROLL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef ASCON_INV_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready[0]), .nrounds(nrounds),
    .x0(x_in[0]), .x1(x_in[1]), .x2(x_in[2]), .x3(x_in[3]), .x4(x_in[4]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .xo0(xo_a[0]), .xo1(xo_a[1]), .xo2(xo_a[2]), .xo3(xo_a[3]), .xo4(xo_a[4])
  );

  ascon_inv_permutation #(.UNROLL(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
`ifdef ASCON_INV_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready[1]), .nrounds(nrounds),
    .x0(x_in[0]), .x1(x_in[1]), .x2(x_in[2]), .x3(x_in[3]), .x4(x_in[4]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .xo0(xo_b[0]), .xo1(xo_b[1]), .xo2(xo_b[2]), .xo3(xo_b[3]), .xo4(xo_b[4])
  );

  task automatic check(input string name, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  // Forward Ascon round: constant addition, S-box, linear diffusion.
  function automatic st_t fwd_round(input st_t s, input int r);
    st_t t;
    int  v;
    s[2][7:0] = s[2][7:0] ^ 8'((15 - r) * 16 + r);
    for (int i = 0; i < 64; i++) begin
      v = fwd_tab[{s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]}];
      for (int w = 0; w < 5; w++) t[w][i] = v[4-w];
    end
    t[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
    t[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
    t[2] = t[2] ^ rotr(t[2],  1) ^ rotr(t[2],  6);
    t[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
    t[4] = t[4] ^ rotr(t[4],  7) ^ rotr(t[4], 41);
    return t;
  endfunction

  function automatic st_t rand_st();
    st_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      out_ready[d] = or_force ? or_val : ($urandom_range(0, 3) != 0);
  end

  task automatic mon(input int d);
    exp_t e;
    st_t  o;
    bit   empty;
    o = (d == 0) ? st_t'(xo_a) : st_t'(xo_b);
    if (!rst_n) begin
      seen[d] = 1'b0;
    end else if (out_valid[d]) begin
      if (!seen[d]) begin
        empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_u%0d got out_valid=1 exp no pending job", d + 1);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check($sformatf("data_u%0d", d + 1), o, e.st);
          check($sformatf("latency_u%0d", d + 1), cyc - e.acc, e.lat);
          check($sformatf("in_ready_busy_u%0d", d + 1), in_ready[d], 1'b0);
        end
        seen[d] = 1'b1;
        held[d] = o;
      end else begin
        check($sformatf("stable_u%0d", d + 1), o, held[d]);
      end
    end else begin
      seen[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(in_ready[0] && in_ready[1]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait_in_budget", (n < 300), 1'b1);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (out_valid != 2'b11 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_wait_in_budget", (n < 100), 1'b1);
  endtask

  // Input = original state pushed through forward rounds 12-a..11; expected output = original.
  task automatic run_job(input st_t s, input logic [3:0] n);
    st_t  inp;
    int   a;
    exp_t e;
    a   = (n > 4'd12) ? 12 : int'(n);
    inp = s;
    for (int r = 12 - a; r < 12; r++) inp = fwd_round(inp, r);
    wait_idle();
    x_in     = inp;
    nrounds  = n;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    e.st  = s;
    e.acc = cyc;
    e.lat = a;
    q0.push_back(e);
    e.lat = (a + 1) / 2;
    q1.push_back(e);
    x_in    = rand_st();
    nrounds = 4'($urandom);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_idle_cleared(input string tag);
    check({tag, "_out_valid"}, out_valid, 2'b00);
    check({tag, "_in_ready"}, in_ready, 2'b11);
    check({tag, "_xo_u1"}, xo_a, '0);
    check({tag, "_xo_u2"}, xo_b, '0);
  endtask

  initial begin
    st_t v;
    for (int i = 0; i < 32; i++) fwd_tab[inv_tab[i]] = i;
    v[0] = 64'h0123456789abcdef;
    v[1] = 64'hfedcba9876543210;
    v[2] = 64'h0;
    v[3] = 64'hffffffffffffffff;
    v[4] = 64'h80400c0600000000;

    #12;
    check_idle_cleared("reset");
    rst_n = 1'b1;

    run_job('0, 4'd1);
    run_job(v, 4'd12);
    run_job(v, 4'd6);
    run_job(v, 4'd7);
    run_job(rand_st(), 4'd0);
    run_job(v, 4'd15);
    run_job(rand_st(), 4'd13);
    run_job(rand_st(), 4'd2);

    // Consumer stalls for 5 cycles in DONE.
    wait_idle();
    or_force = 1'b1;
    or_val   = 1'b0;
    run_job(rand_st(), 4'd3);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 2'b11);
      check("stall_in_ready", in_ready, 2'b00);
    end
    @(posedge clk);
    #1;
    or_val = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", in_ready, 2'b11);
    check("release_out_valid", out_valid, 2'b00);
    or_force = 1'b0;

    // Asynchronous reset in the middle of a 12-round job.
    wait_idle();
    run_job(rand_st(), 4'd12);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_cleared("midrun_reset");
    q0.delete();
    q1.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", in_ready, 2'b11);
    run_job(v, 4'd12);

`ifdef ASCON_INV_ABORT_EN
    wait_idle();
    run_job(rand_st(), 4'd12);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_idle_cleared("abort_run");
    q0.delete();
    q1.delete();

    wait_idle();
    or_force = 1'b1;
    or_val   = 1'b0;
    run_job(rand_st(), 4'd2);
    wait_done();
    @(posedge clk);
    #1;
    abort  = 1'b1;
    or_val = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_idle_cleared("abort_done");
    or_force = 1'b0;
`endif

    for (int j = 0; j < 30; j++) begin
      run_job(rand_st(), 4'($urandom_range(0, 15)));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", q0.size() + q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
